// File: rtl/sync_cdc.sv
// sync_cdc: per-bit multi-stage synchronizer into the clk domain, with
// registered-edge rise/fall/change strobes on the synchronized value.
// Bits resolve independently; use only for independent flags, toggles or
// Gray-coded values.
module sync_cdc #(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] change
);

    // A single stage gives no metastability settling time at all.
    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_cdc: STAGES must be at least 2");
        end
    endgenerate

    // chain[0] is the capture flop; only chain[1] may read it, and so on
    // down the chain. Only the last stage is visible outside.
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0] hist;

    // Synchronizer chain: shift d in at stage 0 every clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    // History of q, so edge strobes last exactly one cycle after q updates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= RESET_VAL;
        end else begin
            hist <= q;
        end
    end

    assign q      = chain[STAGES-1];
    assign rise   = q & ~hist;
    assign fall   = ~q & hist;
    assign change = q ^ hist;

endmodule

// File: tb/tb_sync_cdc.sv
// Directed bench for sync_cdc: three instances cover the default 2-stage
// 1-bit case, a 3-stage latency case and a 4-bit case with non-zero reset.
`timescale 1ns/1ps
module tb_sync_cdc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 1-bit, 2 stages, reset value 0
    logic       rst_w1 = 1'b1;
    logic [0:0] d_w1   = 1'b0;
    logic [0:0] q_w1, rise_w1, fall_w1, change_w1;

    // 1-bit, 3 stages, reset value 0
    logic       rst_s3 = 1'b1;
    logic [0:0] d_s3   = 1'b0;
    logic [0:0] q_s3, rise_s3, fall_s3, change_s3;

    // 4-bit, 2 stages, reset value 0101
    logic       rst_w4 = 1'b1;
    logic [3:0] d_w4   = 4'b0101;
    logic [3:0] q_w4, rise_w4, fall_w4, change_w4;

    sync_cdc #(.WIDTH(1), .STAGES(2), .RESET_VAL(1'b0)) u_w1 (
        .clk(clk), .reset(rst_w1), .d(d_w1),
        .q(q_w1), .rise(rise_w1), .fall(fall_w1), .change(change_w1)
    );

    sync_cdc #(.WIDTH(1), .STAGES(3), .RESET_VAL(1'b0)) u_s3 (
        .clk(clk), .reset(rst_s3), .d(d_s3),
        .q(q_s3), .rise(rise_s3), .fall(fall_s3), .change(change_s3)
    );

    sync_cdc #(.WIDTH(4), .STAGES(2), .RESET_VAL(4'b0101)) u_w4 (
        .clk(clk), .reset(rst_w4), .d(d_w4),
        .q(q_w4), .rise(rise_w4), .fall(fall_w4), .change(change_w4)
    );

    // Advance to 1 ns after the next rising edge; samples and drives happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        d_w1 = 1'b1;
        #1;
        checks++;
        if ({q_w1, rise_w1, fall_w1, change_w1} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_async_t0: q/rise/fall/change=%b required 0000",
                     {q_w1, rise_w1, fall_w1, change_w1});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({q_w1, rise_w1, fall_w1, change_w1} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_hold[%0d]: q/rise/fall/change=%b required 0000",
                         i, {q_w1, rise_w1, fall_w1, change_w1});
            end
        end
        rst_w1 = 1'b0;
        tick();
        checks++;
        if ({q_w1, rise_w1, fall_w1, change_w1} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_release_edge1: q/rise/fall/change=%b required 0000",
                     {q_w1, rise_w1, fall_w1, change_w1});
        end
        tick();
        checks++;
        if ({q_w1, rise_w1, fall_w1, change_w1} !== 4'b1101) begin
            failures++;
            $display("FAIL reset_release_edge2: q/rise/fall/change=%b required 1101",
                     {q_w1, rise_w1, fall_w1, change_w1});
        end
        tick();
        checks++;
        if ({q_w1, rise_w1, fall_w1, change_w1} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_release_edge3: q/rise/fall/change=%b required 1000",
                     {q_w1, rise_w1, fall_w1, change_w1});
        end
    endtask

    // d changes just after "edge 10"; q must update after edge 13 only.
    task automatic test_latency();
        logic [3:0] exp_seq [4];
        rst_s3 = 1'b0;
        d_s3   = 1'b0;
        repeat (5) tick();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                d_s3 = 1'b1;
                exp_seq[0] = 4'b0000; exp_seq[1] = 4'b0000;
                exp_seq[2] = 4'b1101; exp_seq[3] = 4'b1000;
            end else begin
                d_s3 = 1'b0;
                exp_seq[0] = 4'b1000; exp_seq[1] = 4'b1000;
                exp_seq[2] = 4'b0011; exp_seq[3] = 4'b0000;
            end
            for (int e = 0; e < 4; e++) begin
                tick();
                checks++;
                if ({q_s3, rise_s3, fall_s3, change_s3} !== exp_seq[e]) begin
                    failures++;
                    $display("FAIL latency_p%0d_edge%0d: q/rise/fall/change=%b required %b",
                             pass, 11 + e, {q_s3, rise_s3, fall_s3, change_s3}, exp_seq[e]);
                end
            end
        end
    endtask

    task automatic test_toggle();
        int n_change = 0;
        int n_rise   = 0;
        int n_fall   = 0;
        int toggles  = 0;
        logic prev_change = 1'b0;
        logic last_rise   = 1'b0;
        int bad_width = 0;
        int bad_order = 0;
        d_w1 = 1'b0;
        repeat (4) tick();
        for (int cyc = 0; cyc < 28; cyc++) begin
            if ((cyc % 4) == 0 && toggles < 5) begin
                d_w1 = ~d_w1;
                toggles++;
            end
            tick();
            if (change_w1 === 1'b1) begin
                n_change++;
                if (prev_change) bad_width++;
                if (rise_w1 === 1'b1) begin
                    if (n_rise + n_fall > 0 && last_rise) bad_order++;
                    n_rise++;
                    last_rise = 1'b1;
                end
                if (fall_w1 === 1'b1) begin
                    if (n_rise + n_fall == 0 || !last_rise) bad_order++;
                    n_fall++;
                    last_rise = 1'b0;
                end
            end
            prev_change = change_w1;
        end
        checks++;
        if (n_change != 5) begin
            failures++;
            $display("FAIL toggle_change_count: got %0d required 5", n_change);
        end
        checks++;
        if (n_rise != 3 || n_fall != 2) begin
            failures++;
            $display("FAIL toggle_rise_fall_count: rise=%0d fall=%0d required 3/2", n_rise, n_fall);
        end
        checks++;
        if (bad_width != 0 || bad_order != 0) begin
            failures++;
            $display("FAIL toggle_shape: wide=%0d misordered=%0d required 0/0", bad_width, bad_order);
        end
        checks++;
        if (q_w1 !== 1'b1) begin
            failures++;
            $display("FAIL toggle_final_q: got %b required 1", q_w1);
        end
    endtask

    task automatic test_bits();
        rst_w4 = 1'b0;
        d_w4   = 4'b0000;
        repeat (4) tick();
        checks++;
        if ({q_w4, change_w4} !== 8'b0000_0000) begin
            failures++;
            $display("FAIL bits_settle: q/change=%b required 00000000", {q_w4, change_w4});
        end
        d_w4 = 4'b1010;
        tick();
        checks++;
        if ({q_w4, rise_w4} !== 8'b0000_0000) begin
            failures++;
            $display("FAIL bits_edge1: q/rise=%b required 00000000", {q_w4, rise_w4});
        end
        tick();
        checks++;
        if ({q_w4, rise_w4, fall_w4, change_w4} !== 16'b1010_1010_0000_1010) begin
            failures++;
            $display("FAIL bits_edge2: q/rise/fall/change=%b required 1010101000001010",
                     {q_w4, rise_w4, fall_w4, change_w4});
        end
        tick();
        checks++;
        if ({q_w4, rise_w4, fall_w4, change_w4} !== 16'b1010_0000_0000_0000) begin
            failures++;
            $display("FAIL bits_edge3: q/rise/fall/change=%b required 1010000000000000",
                     {q_w4, rise_w4, fall_w4, change_w4});
        end
    endtask

    task automatic test_reset_midflight();
        d_w4 = 4'b1111;
        tick();
        #2;
        rst_w4 = 1'b1;
        #1;
        checks++;
        if ({q_w4, rise_w4, fall_w4, change_w4} !== 16'b0101_0000_0000_0000) begin
            failures++;
            $display("FAIL midflight_async: q/rise/fall/change=%b required 0101000000000000",
                     {q_w4, rise_w4, fall_w4, change_w4});
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({q_w4, rise_w4, fall_w4, change_w4} !== 16'b0101_0000_0000_0000) begin
                failures++;
                $display("FAIL midflight_hold[%0d]: q/rise/fall/change=%b required 0101000000000000",
                         i, {q_w4, rise_w4, fall_w4, change_w4});
            end
        end
        rst_w4 = 1'b0;
        tick();
        checks++;
        if ({q_w4, rise_w4, fall_w4, change_w4} !== 16'b0101_0000_0000_0000) begin
            failures++;
            $display("FAIL midflight_release1: q/rise/fall/change=%b required 0101000000000000",
                     {q_w4, rise_w4, fall_w4, change_w4});
        end
        tick();
        checks++;
        if ({q_w4, rise_w4, fall_w4, change_w4} !== 16'b1111_1010_0000_1010) begin
            failures++;
            $display("FAIL midflight_release2: q/rise/fall/change=%b required 1111101000001010",
                     {q_w4, rise_w4, fall_w4, change_w4});
        end
        tick();
        checks++;
        if ({q_w4, change_w4} !== 8'b1111_0000) begin
            failures++;
            $display("FAIL midflight_release3: q/change=%b required 11110000", {q_w4, change_w4});
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_toggle();
        test_bits();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_cdc.md
Name: sync_cdc

Overview:
- Multi-bit, per-bit-independent clock-domain-crossing synchronizer.
- Brings asynchronous level signals into the `clk` domain, e.g. armed/running status into the JTAG DRCK domain, or a JTAG-side arm toggle into the capture clock domain.
- Also produces registered rise, fall and change pulses on the synchronized value, so a toggle handshake can be decoded without extra logic at the destination.

Parameters:
- WIDTH, 1: number of independent bits synchronized.
- STAGES, 2: flip-flop stages in each bit's synchronizer chain. Must be ≥2; elaboration fails otherwise.
- RESET_VAL, 0 (WIDTH bits): value loaded into every stage, `q`, and the history register on reset.

Ports:
- clk  in  1  destination-domain clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- d  in  WIDTH  asynchronous source-domain level input.
- q  out  WIDTH  synchronized copy of `d` (last chain stage).
- rise  out  WIDTH  one-cycle pulse per bit when `q` goes 0→1.
- fall  out  WIDTH  one-cycle pulse per bit when `q` goes 1→0.
- change  out  WIDTH  one-cycle pulse per bit on any `q` transition (rise | fall).

Behaviour:
- One clock; reset is asynchronous and active-high (ports `clk`, `reset`).
- Per bit i, chain s[0..STAGES-1]:
  - Each rising `clk`: s[0] <= d[i], s[k] <= s[k-1].
  - q[i] = s[STAGES-1], driven directly from that flop.
- History register h:
  - h <= q each rising `clk`.
  - rise = q & ~h; fall = ~q & h; change = q ^ h.
  - These are combinational from two flops; no further logic on the path.
- Latency:
  - A `d` value stable across rising edge n appears on `q` after edge n+STAGES-1, i.e. STAGES edges counting edge n.
  - The matching rise/fall/change pulse is high for exactly the one cycle after `q` updates, then clears unless `q` changes again.
- Reset:
  - While `reset` is high, all s[], h and `q` equal RESET_VAL, independent of `clk`.
  - rise, fall and change are 0 during reset and on the first cycle after release, because h == q == RESET_VAL.
  - Reset release is not synchronized internally; the integrator provides a synchronously-deasserted reset.
  - Reset asserted mid-propagation discards in-flight values; no pulse is generated for them.
- `d` pulses shorter than one `clk` period plus setup/hold may be lost. Source signals must be levels or toggles held ≥2 destination periods.
- Multi-bit bus coherency is not guaranteed: bits resolve independently and may land one cycle apart. Use only for independent flags or Gray-coded values.
- Toggle handshake:
  - The source flips a bit to send an event.
  - The destination consumes `change` as a single-cycle event strobe.
  - Back-to-back flips spaced ≥2 destination cycles produce one `change` pulse each.
- Metastability:
  - No logic may read s[0..STAGES-2] other than the next stage.
  - Chain flops carry an ASYNC_REG attribute (synthesis hint only).

Test Plan:
- Reset: WIDTH=1, RESET_VAL=0, `d`=1 during reset → q=0, rise=fall=change=0 throughout. After release q=1 at the 2nd rising edge, rise=1 for exactly one cycle.
- Latency: STAGES=3, `d` 0→1 just after edge 10 → q=1 after edge 13 (not earlier). rise and change high only between edges 13 and 14. Falling-edge test gives `fall` with the same timing.
- Toggle events: `d` toggled every 4 clk cycles, 5 times → exactly 5 change pulses, alternating rise/fall, each 1 cycle wide; q ends at 1.
- Independent bits: WIDTH=4, `d` 0000→1010 → q=1010 after 2 edges. rise=1010 for one cycle, fall=0000.
- Reset mid-flight: RESET_VAL=4'b0101, `d`=1111, reset asserted asynchronously one cycle after `d` changes → q immediately 0101, no pulses. After release q=1111 two edges later, with rise=1010.
- Illegal parameter: STAGES=1 → elaboration error.
